// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: resolves ALU operands (with optional EX/MEM forwarding),
// detects load-use hazards and registers the ID/EX pipeline fields. Macro: OPERAND_FWD_EN.
module id_ex_operand_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_rt_used,
  input  logic [15:0]   id_imm,
  input  logic          id_sext,
  input  logic          id_aluimm,
  input  logic          id_wreg,
  input  logic          id_m2reg,
  input  logic          id_wmem,
  input  logic [3:0]    id_aluc,
  input  logic [RW-1:0] id_rn,
  input  logic [DW-1:0] rf_qa,
  input  logic [DW-1:0] rf_qb,
  input  logic [RW-1:0] ex_rn_i,
  input  logic          ex_wreg_i,
  input  logic          ex_m2reg_i,
  input  logic [DW-1:0] ex_alu_i,
  input  logic [RW-1:0] mem_rn_i,
  input  logic          mem_wreg_i,
  input  logic          mem_m2reg_i,
  input  logic [DW-1:0] mem_alu_i,
  input  logic [DW-1:0] mem_ld_i,
  output logic          lu_stall,
  output logic          ex_valid,
  output logic [DW-1:0] ex_qa,
  output logic [DW-1:0] ex_qb,
  output logic [DW-1:0] ex_se_imm,
  output logic          ex_aluimm,
  output logic          ex_wreg,
  output logic          ex_m2reg,
  output logic          ex_wmem,
  output logic [3:0]    ex_aluc,
  output logic [RW-1:0] ex_rn
);

  logic [DW-1:0] w_se_imm, w_qa, w_qb;
  logic          w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt, w_bubble, w_load;

  assign w_se_imm = id_sext ? {{(DW-16){id_imm[15]}}, id_imm} : {{(DW-16){1'b0}}, id_imm};

  // Writer matches exclude r0, so r0 always reads the register file.
  assign w_ex_rs  = ex_wreg_i  && (ex_rn_i  != '0) && (ex_rn_i  == id_rs);
  assign w_ex_rt  = ex_wreg_i  && (ex_rn_i  != '0) && (ex_rn_i  == id_rt);
  assign w_mem_rs = mem_wreg_i && (mem_rn_i != '0) && (mem_rn_i == id_rs);
  assign w_mem_rt = mem_wreg_i && (mem_rn_i != '0) && (mem_rn_i == id_rt);

`ifdef OPERAND_FWD_EN
  always_comb begin
    w_qa = rf_qa;
    if (w_ex_rs && !ex_m2reg_i) w_qa = ex_alu_i;
    else if (w_mem_rs)          w_qa = mem_m2reg_i ? mem_ld_i : mem_alu_i;
  end

  // B forwards regardless of aluimm: stores carry rt through to MEM.
  always_comb begin
    w_qb = rf_qb;
    if (w_ex_rt && !ex_m2reg_i) w_qb = ex_alu_i;
    else if (w_mem_rt)          w_qb = mem_m2reg_i ? mem_ld_i : mem_alu_i;
  end

  assign lu_stall = id_valid && ex_m2reg_i && (w_ex_rs || (id_rt_used && w_ex_rt));
`else
  assign w_qa = rf_qa;
  assign w_qb = rf_qb;

  // Without forwarding any in-flight writer of a source register must drain first.
  assign lu_stall = id_valid && (w_ex_rs || w_mem_rs || (id_rt_used && (w_ex_rt || w_mem_rt)));
`endif

  assign w_bubble = flush || lu_stall || !id_valid;
  assign w_load   = flush || !hold;

  logic          r_valid, r_aluimm, r_wreg, r_m2reg, r_wmem;
  logic [DW-1:0] r_qa, r_qb, r_se_imm;
  logic [3:0]    r_aluc;
  logic [RW-1:0] r_rn;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_qa     <= '0;
      r_qb     <= '0;
      r_se_imm <= '0;
      r_aluimm <= 1'b0;
      r_wreg   <= 1'b0;
      r_m2reg  <= 1'b0;
      r_wmem   <= 1'b0;
      r_aluc   <= '0;
      r_rn     <= '0;
    end else if (w_load) begin
      r_valid  <= !w_bubble;
      r_qa     <= w_qa;
      r_qb     <= w_qb;
      r_se_imm <= w_se_imm;
      r_aluimm <= id_aluimm;
      r_wreg   <= id_wreg  && !w_bubble;
      r_m2reg  <= id_m2reg && !w_bubble;
      r_wmem   <= id_wmem  && !w_bubble;
      r_aluc   <= id_aluc;
      r_rn     <= id_rn;
    end
  end

  assign ex_valid  = r_valid;
  assign ex_qa     = r_qa;
  assign ex_qb     = r_qb;
  assign ex_se_imm = r_se_imm;
  assign ex_aluimm = r_aluimm;
  assign ex_wreg   = r_wreg;
  assign ex_m2reg  = r_m2reg;
  assign ex_wmem   = r_wmem;
  assign ex_aluc   = r_aluc;
  assign ex_rn     = r_rn;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage; expectations follow the OPERAND_FWD_EN build setting.
module tb_id_ex_operand_stage;

`ifdef OPERAND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, hold, flush, id_valid, id_rt_used, id_sext, id_aluimm;
  logic        id_wreg, id_m2reg, id_wmem;
  logic [4:0]  id_rs, id_rt, id_rn, ex_rn_i, mem_rn_i;
  logic [15:0] id_imm;
  logic [3:0]  id_aluc;
  logic [31:0] rf_qa, rf_qb, ex_alu_i, mem_alu_i, mem_ld_i;
  logic        ex_wreg_i, ex_m2reg_i, mem_wreg_i, mem_m2reg_i;
  logic        lu_stall, ex_valid, ex_aluimm, ex_wreg, ex_m2reg, ex_wmem;
  logic [31:0] ex_qa, ex_qb, ex_se_imm;
  logic [3:0]  ex_aluc;
  logic [4:0]  ex_rn;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rt_used(id_rt_used), .id_imm(id_imm),
    .id_sext(id_sext), .id_aluimm(id_aluimm), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
    .id_wmem(id_wmem), .id_aluc(id_aluc), .id_rn(id_rn), .rf_qa(rf_qa), .rf_qb(rf_qb),
    .ex_rn_i(ex_rn_i), .ex_wreg_i(ex_wreg_i), .ex_m2reg_i(ex_m2reg_i), .ex_alu_i(ex_alu_i),
    .mem_rn_i(mem_rn_i), .mem_wreg_i(mem_wreg_i), .mem_m2reg_i(mem_m2reg_i),
    .mem_alu_i(mem_alu_i), .mem_ld_i(mem_ld_i), .lu_stall(lu_stall), .ex_valid(ex_valid),
    .ex_qa(ex_qa), .ex_qb(ex_qb), .ex_se_imm(ex_se_imm), .ex_aluimm(ex_aluimm),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem), .ex_aluc(ex_aluc), .ex_rn(ex_rn)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    rst = 0; hold = 0; flush = 0; id_valid = 0; id_rt_used = 0; id_sext = 0; id_aluimm = 0;
    id_wreg = 0; id_m2reg = 0; id_wmem = 0; id_rs = 0; id_rt = 0; id_rn = 0; id_imm = 0;
    id_aluc = 0; rf_qa = 0; rf_qb = 0; ex_rn_i = 0; ex_wreg_i = 0; ex_m2reg_i = 0;
    ex_alu_i = 0; mem_rn_i = 0; mem_wreg_i = 0; mem_m2reg_i = 0; mem_alu_i = 0; mem_ld_i = 0;
  endtask

  task automatic test_reset();
    clr_inputs();
    rst = 1;
    tick(); tick();
    checks++;
    if ({ex_valid, ex_qa, ex_qb, ex_se_imm, ex_aluimm, ex_wreg, ex_m2reg, ex_wmem, ex_aluc, ex_rn} !== '0) begin
      errors++; $display("FAIL reset_outputs got valid=%b qa=%h qb=%h imm=%h rn=%h exp all zero",
                         ex_valid, ex_qa, ex_qb, ex_se_imm, ex_rn);
    end
    checks++;
    if (lu_stall !== 1'b0) begin errors++; $display("FAIL reset_lu_stall got %b exp 0", lu_stall); end
    rst = 0;
  endtask

  task automatic test_extend();
    clr_inputs();
    id_valid = 1; id_imm = 16'h8001; id_sext = 1; id_wreg = 1; id_aluc = 4'hA; id_rn = 5'd9;
    tick();
    checks++;
    if (ex_se_imm !== 32'hFFFF8001) begin errors++; $display("FAIL sext_imm got %h exp FFFF8001", ex_se_imm); end
    checks++;
    if ({ex_valid, ex_wreg, ex_aluc, ex_rn} !== {1'b1, 1'b1, 4'hA, 5'd9}) begin
      errors++; $display("FAIL ctrl_pass got v=%b w=%b aluc=%h rn=%0d exp 1 1 a 9", ex_valid, ex_wreg, ex_aluc, ex_rn);
    end
    id_sext = 0;
    tick();
    checks++;
    if (ex_se_imm !== 32'h00008001) begin errors++; $display("FAIL zext_imm got %h exp 00008001", ex_se_imm); end
  endtask

  task automatic test_ex_forward();
    clr_inputs();
    id_valid = 1; id_rs = 5'd5; id_wreg = 1;
    ex_wreg_i = 1; ex_rn_i = 5'd5; ex_alu_i = 32'h1234;
    #1;
    checks++;
    if (lu_stall !== !FWD) begin errors++; $display("FAIL ex_fwd_stall got %b exp %b", lu_stall, !FWD); end
    tick();
    checks++;
    if ({ex_valid, ex_qa} !== {FWD, (FWD ? 32'h1234 : 32'h0)}) begin
      errors++; $display("FAIL ex_fwd_qa got v=%b qa=%h exp v=%b", ex_valid, ex_qa, FWD);
    end
    mem_wreg_i = 1; mem_rn_i = 5'd5; mem_alu_i = 32'hBEEF;
    tick();
    checks++;
    if (ex_qa !== (FWD ? 32'h1234 : 32'h0)) begin
      errors++; $display("FAIL ex_over_mem got %h exp %h", ex_qa, (FWD ? 32'h1234 : 32'h0));
    end
  endtask

  task automatic test_mem_load();
    clr_inputs();
    id_valid = 1; id_rt = 5'd7; id_rt_used = 1; id_aluimm = 1; rf_qb = 32'h1111;
    mem_wreg_i = 1; mem_m2reg_i = 1; mem_rn_i = 5'd7; mem_ld_i = 32'hCAFE; mem_alu_i = 32'hDEAD;
    #1;
    checks++;
    if (lu_stall !== !FWD) begin errors++; $display("FAIL mem_ld_stall got %b exp %b", lu_stall, !FWD); end
    tick();
    checks++;
    if ({ex_valid, ex_aluimm, ex_qb} !== {FWD, 1'b1, (FWD ? 32'hCAFE : 32'h1111)}) begin
      errors++; $display("FAIL mem_ld_qb got v=%b ai=%b qb=%h exp v=%b ai=1", ex_valid, ex_aluimm, ex_qb, FWD);
    end
    // Writers targeting r0 must be ignored in both builds.
    id_rs = 0; id_rt = 0; rf_qa = 32'h55; rf_qb = 32'h66;
    ex_wreg_i = 1; ex_rn_i = 0; ex_alu_i = 32'hFFFF_FFFF; mem_rn_i = 0; mem_m2reg_i = 0;
    mem_alu_i = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (lu_stall !== 1'b0) begin errors++; $display("FAIL r0_stall got %b exp 0", lu_stall); end
    tick();
    checks++;
    if ({ex_valid, ex_qa, ex_qb} !== {1'b1, 32'h55, 32'h66}) begin
      errors++; $display("FAIL r0_no_fwd got v=%b qa=%h qb=%h exp 1 55 66", ex_valid, ex_qa, ex_qb);
    end
  endtask

  task automatic test_load_use();
    clr_inputs();
    id_valid = 1; id_rs = 5'd3; id_wreg = 1; id_wmem = 1;
    ex_wreg_i = 1; ex_m2reg_i = 1; ex_rn_i = 5'd3;
    #1;
    checks++;
    if (lu_stall !== 1'b1) begin errors++; $display("FAIL lu_rs got %b exp 1", lu_stall); end
    tick();
    checks++;
    if ({ex_valid, ex_wreg, ex_wmem} !== 3'b000) begin
      errors++; $display("FAIL lu_bubble got v=%b w=%b m=%b exp 000", ex_valid, ex_wreg, ex_wmem);
    end
    id_rs = 5'd1; id_rt = 5'd3; id_rt_used = 0;
    #1;
    checks++;
    if (lu_stall !== 1'b0) begin errors++; $display("FAIL lu_rt_unused got %b exp 0", lu_stall); end
    id_rt_used = 1;
    #1;
    checks++;
    if (lu_stall !== 1'b1) begin errors++; $display("FAIL lu_rt_used got %b exp 1", lu_stall); end
    id_valid = 0;
    #1;
    checks++;
    if (lu_stall !== 1'b0) begin errors++; $display("FAIL lu_invalid got %b exp 0", lu_stall); end
    tick();
    checks++;
    if ({ex_valid, ex_wreg, ex_wmem} !== 3'b000) begin
      errors++; $display("FAIL invalid_bubble got v=%b w=%b m=%b exp 000", ex_valid, ex_wreg, ex_wmem);
    end
  endtask

  task automatic test_hold_flush();
    clr_inputs();
    id_valid = 1; id_rs = 5'd1; rf_qa = 32'hA; id_wreg = 1;
    tick();
    checks++;
    if ({ex_valid, ex_qa} !== {1'b1, 32'hA}) begin errors++; $display("FAIL hf_load got v=%b qa=%h exp 1 a", ex_valid, ex_qa); end
    hold = 1; rf_qa = 32'hB;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({ex_valid, ex_qa} !== {1'b1, 32'hA}) begin
        errors++; $display("FAIL hold_%0d got v=%b qa=%h exp 1 a", i, ex_valid, ex_qa);
      end
    end
    // A hazard during hold is still reported but must not bubble the held entry.
    ex_wreg_i = 1; ex_m2reg_i = 1; ex_rn_i = 5'd1;
    #1;
    checks++;
    if (lu_stall !== 1'b1) begin errors++; $display("FAIL hold_lu_stall got %b exp 1", lu_stall); end
    tick();
    checks++;
    if ({ex_valid, ex_qa} !== {1'b1, 32'hA}) begin errors++; $display("FAIL hold_over_lu got v=%b qa=%h exp 1 a", ex_valid, ex_qa); end
    ex_wreg_i = 0; ex_m2reg_i = 0; flush = 1;
    tick();
    checks++;
    if ({ex_valid, ex_wreg} !== 2'b00) begin errors++; $display("FAIL flush_over_hold got v=%b w=%b exp 00", ex_valid, ex_wreg); end
    flush = 0; hold = 0; rf_qa = 32'hC;
    tick();
    hold = 1; rst = 1;
    tick();
    checks++;
    if ({ex_valid, ex_qa, ex_wreg, ex_rn} !== '0) begin
      errors++; $display("FAIL rst_over_hold got v=%b qa=%h w=%b exp zeros", ex_valid, ex_qa, ex_wreg);
    end
    rst = 0; hold = 0;
  endtask

  task automatic test_mem_alu();
    clr_inputs();
    id_valid = 1; id_rs = 5'd4; rf_qa = 32'h44;
    mem_wreg_i = 1; mem_rn_i = 5'd4; mem_alu_i = 32'h999; mem_ld_i = 32'h777;
    #1;
    checks++;
    if (lu_stall !== !FWD) begin errors++; $display("FAIL mem_alu_stall got %b exp %b", lu_stall, !FWD); end
    tick();
    checks++;
    if ({ex_valid, ex_qa} !== {FWD, (FWD ? 32'h999 : 32'h44)}) begin
      errors++; $display("FAIL mem_alu_qa got v=%b qa=%h exp v=%b qa=%h", ex_valid, ex_qa, FWD, (FWD ? 32'h999 : 32'h44));
    end
  endtask

  initial begin
    test_reset();
    test_extend();
    test_ex_forward();
    test_mem_load();
    test_load_use();
    test_hold_flush();
    test_mem_alu();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
